aes_round_key_sched: RTL

Sequential AES-128 round-key generator that feeds the encryption and decryption round datapaths. It accepts a 128-bit cipher key and delivers the 11 round keys one per handshake. Encryption order is forward (K0→K10). Decryption order is reverse (K10→K0): the block first expands forward to K10, then walks the key schedule backward on the fly. It instantiates four `sbox_in_JSSC` byte S-boxes with `mode` tied to 1'b0 (forward SubWord only).

---
 rtl/aes_round_key_sched.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_round_key_sched.sv
// AES-128 round-key scheduler.
// Produces K0..K10 (encryption order) or K10..K0 (decryption order), one key per
// rk_valid/rk_ack handshake. Decryption order first runs the forward schedule up
// to K10, then steps backward on the fly. A single 4-byte S-box bank is shared
// between the forward step and the inverse step.

// Single AES byte S-box computed arithmetically: GF(2^8) inverse plus affine map.
// mode=0 selects the forward S-box and mode=1 selects the inverse S-box.
module sbox_in_JSSC (
  input  logic [7:0] din,
  input  logic       mode,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = (x^127)^2; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 0; k < 7; k++) begin
      r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  logic [7:0] w_pre;

  // Forward: inverse then affine. Inverse: inverse affine then inverse.
  always_comb begin
    w_pre = 8'h00;
    dout  = 8'h00;
    if (!mode) begin
      w_pre = gf_inv(din);
      dout  = w_pre ^ rotl(w_pre, 1) ^ rotl(w_pre, 2) ^ rotl(w_pre, 3)
              ^ rotl(w_pre, 4) ^ 8'h63;
    end else begin
      w_pre = rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05;
      dout  = gf_inv(w_pre);
    end
  end

endmodule

module aes_round_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic         mode,
  input  logic         rk_ack,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_SERVE} state_t;

  state_t       r_state, w_state_next;
  logic         r_mode, w_mode_next;
  logic [127:0] r_key, w_key_next;
  logic [3:0]   r_idx, w_idx_next;
  logic         r_done, w_done_next;

  logic [31:0]  w_a0, w_a1, w_a2, w_a3;
  logic [31:0]  w_inv_b1, w_inv_b2, w_inv_b3;
  logic [31:0]  w_fwd_b0, w_fwd_b1, w_fwd_b2, w_fwd_b3;
  logic         w_inv_sel;
  logic [31:0]  w_sb_word, w_rot, w_sub, w_t;
  logic [3:0]   w_rcon_idx;
  logic [7:0]   w_rcon;
  logic [127:0] w_fwd_key, w_inv_key;

  function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign w_a0 = r_key[127:96];
  assign w_a1 = r_key[95:64];
  assign w_a2 = r_key[63:32];
  assign w_a3 = r_key[31:0];

  // Inverse step recovers the last three words of K(i-1) with XORs alone.
  assign w_inv_b3 = w_a3 ^ w_a2;
  assign w_inv_b2 = w_a2 ^ w_a1;
  assign w_inv_b1 = w_a1 ^ w_a0;

  // Only a backward walk in SERVE uses the inverse step; everything else is forward.
  assign w_inv_sel  = (r_state == S_SERVE) && r_mode;
  assign w_sb_word  = w_inv_sel ? w_inv_b3 : w_a3;
  assign w_rot      = {w_sb_word[23:0], w_sb_word[31:24]};
  assign w_rcon_idx = w_inv_sel ? r_idx : r_idx + 4'd1;
  assign w_rcon     = rcon_lut(w_rcon_idx);

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    sbox_in_JSSC u_sbox (
      .din  (w_rot[8*gi +: 8]),
      .mode (1'b0),
      .dout (w_sub[8*gi +: 8])
    );
  end

  assign w_t = w_sub ^ {w_rcon, 24'h0};

  assign w_fwd_b0  = w_a0 ^ w_t;
  assign w_fwd_b1  = w_a1 ^ w_fwd_b0;
  assign w_fwd_b2  = w_a2 ^ w_fwd_b1;
  assign w_fwd_b3  = w_a3 ^ w_fwd_b2;
  assign w_fwd_key = {w_fwd_b0, w_fwd_b1, w_fwd_b2, w_fwd_b3};
  assign w_inv_key = {w_a0 ^ w_t, w_inv_b1, w_inv_b2, w_inv_b3};

  // Next-state logic: load, forward expansion, and handshake-driven key stepping.
  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    w_key_next   = r_key;
    w_idx_next   = r_idx;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (key_load) begin
          w_key_next   = key_in;
          w_mode_next  = mode;
          w_idx_next   = 4'd0;
          w_state_next = mode ? S_EXPAND : S_SERVE;
        end
      end
      S_EXPAND: begin
        w_key_next = w_fwd_key;
        w_idx_next = r_idx + 4'd1;
        if (r_idx == 4'd9) w_state_next = S_SERVE;
      end
      S_SERVE: begin
        if (rk_ack) begin
          if (!r_mode) begin
            if (r_idx == 4'd10) begin
              w_state_next = S_IDLE;
              w_done_next  = 1'b1;
            end else begin
              w_key_next = w_fwd_key;
              w_idx_next = r_idx + 4'd1;
            end
          end else begin
            if (r_idx == 4'd0) begin
              w_state_next = S_IDLE;
              w_done_next  = 1'b1;
            end else begin
              w_key_next = w_inv_key;
              w_idx_next = r_idx - 4'd1;
            end
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_key   <= 128'h0;
      r_idx   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_key   <= w_key_next;
      r_idx   <= w_idx_next;
      r_done  <= w_done_next;
    end
  end

  assign rk_valid = (r_state == S_SERVE);
  assign rk_out   = r_key;
  assign rk_idx   = r_idx;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;

endmodule
